// File: rtl/operand_capture_fsm_pkg.sv
// operand_capture_fsm_pkg: shared calculator types, width and operand re-biasing helper
package operand_capture_fsm_pkg;

    localparam int CALC_WIDTH = 4;

    typedef enum logic [1:0] {
        S_NEED_A,
        S_NEED_B,
        S_READY
    } state_t;

    function automatic logic [CALC_WIDTH-1:0] bias_msb(input logic [CALC_WIDTH-1:0] value, input logic signed_mode);
        return value ^ {signed_mode, {(CALC_WIDTH-1){1'b0}}};
    endfunction

endpackage

// File: rtl/operand_capture_fsm_load_debouncer.sv
// operand_capture_fsm_load_debouncer: synchronise and debounce a raw button, pulse once per debounced press
module operand_capture_fsm_load_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Raw,
    output logic Press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // two-flop synchroniser, disagreement counter, and rising-edge pulse of the debounced level
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            Press <= 1'b0;
        end else begin
            sync  <= {sync[0], Raw};
            Press <= sync[1] & ~level & (cnt == LAST);
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_capture_fsm.sv
// operand_capture_fsm: capture two operands on debounced Load presses and present them re-biased to the comparator
module operand_capture_fsm
    import operand_capture_fsm_pkg::*;
#(
    parameter int WIDTH           = CALC_WIDTH,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Load,
    input  logic             Clear,
    input  logic             Signed_Mode,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Need_A,
    output logic             Need_B,
    output logic             Operands_Valid
);

    state_t           state;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic             press;

    operand_capture_fsm_load_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) load_debouncer (
        .Clk  (Clk),
        .Reset(Reset),
        .Raw  (Load),
        .Press(press)
    );

    // entry FSM: capture on press, Clear overrides, status decoded from the next state, operands mapped a cycle behind
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state                             <= S_NEED_A;
            a_raw                             <= '0;
            b_raw                             <= '0;
            A                                 <= '0;
            B                                 <= '0;
            {Need_A, Need_B, Operands_Valid}  <= 3'b100;
        end else begin
            A <= bias_msb(a_raw, Signed_Mode);
            B <= bias_msb(b_raw, Signed_Mode);
            if (Clear) begin
                state                            <= S_NEED_A;
                a_raw                            <= '0;
                b_raw                            <= '0;
                {Need_A, Need_B, Operands_Valid} <= 3'b100;
            end else if (press) begin
                case (state)
                    S_NEED_B: begin
                        b_raw                            <= Data_In;
                        state                            <= S_READY;
                        {Need_A, Need_B, Operands_Valid} <= 3'b001;
                    end
                    default: begin
                        a_raw                            <= Data_In;
                        state                            <= S_NEED_B;
                        {Need_A, Need_B, Operands_Valid} <= 3'b010;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_capture_fsm.sv
// tb_operand_capture_fsm: directed and randomized checks of operand_capture_fsm against a behavioural model
module tb_operand_capture_fsm;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Load = 1'b0;
    logic         Clear = 1'b0;
    logic         Signed_Mode = 1'b0;
    logic [W-1:0] Data_In = '0;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Need_A;
    logic         Need_B;
    logic         Operands_Valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    operand_capture_fsm #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Data_In       (Data_In),
        .Load          (Load),
        .Clear         (Clear),
        .Signed_Mode   (Signed_Mode),
        .A             (A),
        .B             (B),
        .Need_A        (Need_A),
        .Need_B        (Need_B),
        .Operands_Valid(Operands_Valid)
    );

    // behavioural model: Load seen two edges late, level flips after DC straight disagreeing samples,
    // a press is acted on the edge after the level rises, outputs show the mapped operands one edge late
    bit raw_q[$];
    bit sync_q[$];
    bit m_deb, m_press, s_now, tog;
    int m_stage, m_a, m_b, m_A, m_B;

    function automatic int map(int v, bit sm);
        return sm ? (v + 2 ** (W - 1)) % (2 ** W) : v;
    endfunction

    always @(posedge Clk) begin
        if (Reset) begin
            raw_q.delete();
            sync_q.delete();
            m_deb = 0; m_press = 0; m_stage = 0;
            m_a = 0; m_b = 0; m_A = 0; m_B = 0;
        end else begin
            s_now = raw_q.size() >= 2 ? raw_q[raw_q.size() - 2] : 1'b0;
            sync_q.push_back(s_now);
            if (sync_q.size() > DC) void'(sync_q.pop_front());
            tog = sync_q.size() == DC;
            foreach (sync_q[i]) if (sync_q[i] == m_deb) tog = 0;
            m_A = map(m_a, Signed_Mode);
            m_B = map(m_b, Signed_Mode);
            if (Clear) begin
                m_stage = 0; m_a = 0; m_b = 0;
            end else if (m_press) begin
                if (m_stage == 1) begin
                    m_b = int'(Data_In); m_stage = 2;
                end else begin
                    m_a = int'(Data_In); m_stage = 1;
                end
            end
            m_press = tog && !m_deb;
            if (tog) m_deb = !m_deb;
            raw_q.push_back(Load);
            if (raw_q.size() > 2) void'(raw_q.pop_front());
        end
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            check("model_A", 32'(A), 32'(m_A));
            check("model_B", 32'(B), 32'(m_B));
            check("model_need_a", 32'(Need_A), 32'(m_stage == 0));
            check("model_need_b", 32'(Need_B), 32'(m_stage == 1));
            check("model_valid", 32'(Operands_Valid), 32'(m_stage == 2));
        end
    endtask

    task automatic press(logic [W-1:0] v);
        Data_In = v;
        Load = 1'b1;
        cyc(DC + 4);
        Load = 1'b0;
        cyc(DC + 4);
    endtask

    initial begin
        cyc(3);
        check("rst_a", 32'(A), 0);
        check("rst_b", 32'(B), 0);
        check("rst_need_a", 32'(Need_A), 1);
        check("rst_need_b", 32'(Need_B), 0);
        check("rst_valid", 32'(Operands_Valid), 0);

        Reset = 1'b0;
        Load = 1'b1;
        Data_In = 4'h3;
        cyc(6);
        check("pre_edge6_need_a", 32'(Need_A), 1);
        cyc(1);
        check("edge6_need_b", 32'(Need_B), 1);
        cyc(1);
        check("edge7_a", 32'(A), 4'h3);
        Load = 1'b0;
        cyc(2 * DC + 4);
        press(4'h9);
        check("clean_a", 32'(A), 4'h3);
        check("clean_b", 32'(B), 4'h9);
        check("clean_valid", 32'(Operands_Valid), 1);

        Clear = 1'b1;
        cyc(1);
        Clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Load = ~Load;
            Data_In = W'(i);
            cyc(2);
        end
        Load = 1'b1;
        Data_In = 4'h5;
        cyc(4 * DC);
        check("bounce_need_b", 32'(Need_B), 1);
        check("bounce_a", 32'(A), 4'h5);
        Load = 1'b0;
        cyc(2 * DC + 4);

        Clear = 1'b1;
        cyc(1);
        Clear = 1'b0;
        Signed_Mode = 1'b1;
        press(4'hD);
        press(4'h2);
        check("signed_a", 32'(A), 4'h5);
        check("signed_b", 32'(B), 4'hA);
        Signed_Mode = 1'b0;
        cyc(1);
        check("unsigned_a", 32'(A), 4'hD);
        check("unsigned_b", 32'(B), 4'h2);
        check("mode_valid", 32'(Operands_Valid), 1);

        press(4'h7);
        check("reload_a", 32'(A), 4'h7);
        check("reload_b", 32'(B), 4'h2);
        check("reload_valid", 32'(Operands_Valid), 0);
        check("reload_need_b", 32'(Need_B), 1);

        Data_In = 4'hF;
        Load = 1'b1;
        cyc(DC + 2);
        Clear = 1'b1;
        cyc(1);
        Clear = 1'b0;
        check("clr_press_need_a", 32'(Need_A), 1);
        cyc(1);
        check("clr_press_a", 32'(A), 0);
        check("clr_press_b", 32'(B), 0);
        cyc(3 * DC);
        check("held_no_repress", 32'(Need_A), 1);
        Load = 1'b0;
        cyc(2 * DC + 4);

        Load = 1'b1;
        Data_In = 4'hC;
        cyc(DC);
        Reset = 1'b1;
        cyc(2);
        check("mid_rst_need_a", 32'(Need_A), 1);
        check("mid_rst_a", 32'(A), 0);
        Reset = 1'b0;
        cyc(DC + 2);
        check("post_rst_wait", 32'(Need_A), 1);
        cyc(1);
        check("post_rst_press", 32'(Need_B), 1);
        Load = 1'b0;
        cyc(2 * DC + 4);

        repeat (120) begin
            Load = 1'($urandom_range(0, 1));
            Data_In = W'($urandom);
            if ($urandom_range(0, 7) == 0) Signed_Mode = ~Signed_Mode;
            Clear = $urandom_range(0, 19) == 0;
            cyc(1);
            Clear = 1'b0;
            cyc($urandom_range(0, 12));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
